// File: rtl/multiplier_pipe_pkg.sv
// Shared types and defaults for the SpMV multiply stage and its neighbours.
package multiplier_pipe_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int IDX_W_DEF  = 10;

   typedef logic signed [DATA_W_DEF-1:0] data_t;
   typedef logic [IDX_W_DEF-1:0]         idx_t;

   typedef enum logic {
      SAT_WRAP  = 1'b0,
      SAT_CLAMP = 1'b1
   } sat_mode_e;

   // Narrow a default-width full product to data_t, wrapping or clamping.
   function automatic data_t saturate(input logic signed [2*DATA_W_DEF-1:0] full,
                                      input sat_mode_e mode);
      logic ovf;
      ovf = (full[2*DATA_W_DEF-1:DATA_W_DEF-1] != {(DATA_W_DEF+1){full[2*DATA_W_DEF-1]}});
      if (mode == SAT_CLAMP && ovf)
         saturate = full[2*DATA_W_DEF-1] ? {1'b1, {(DATA_W_DEF-1){1'b0}}}
                                         : {1'b0, {(DATA_W_DEF-1){1'b1}}};
      else
         saturate = full[DATA_W_DEF-1:0];
   endfunction

endpackage

// File: rtl/multiplier_pipe_if.sv
// Input beat / output product stream bundle for multiplier_pipe.
interface multiplier_pipe_if #(
   parameter int NUM_CHANNELS = 4,
   parameter int DATA_W       = 32,
   parameter int IDX_W        = 10
);
   logic                           in_valid;
   logic                           in_ready;
   logic [NUM_CHANNELS*DATA_W-1:0] in_values;
   logic [NUM_CHANNELS*IDX_W-1:0]  in_cols;
   logic [NUM_CHANNELS-1:0]        in_mask;
   logic                           in_last;
   logic                           out_valid;
   logic                           out_ready;
   logic [NUM_CHANNELS*DATA_W-1:0] out_products;
   logic [NUM_CHANNELS-1:0]        out_mask;
   logic                           out_last;

   // Upstream producer / downstream consumer side.
   modport master (
      output in_valid, in_values, in_cols, in_mask, in_last, out_ready,
      input  in_ready, out_valid, out_products, out_mask, out_last
   );

   // The multiply stage itself.
   modport slave (
      input  in_valid, in_values, in_cols, in_mask, in_last, out_ready,
      output in_ready, out_valid, out_products, out_mask, out_last
   );
endinterface

// File: rtl/multiplier_pipe_vector_bank.sv
// Dense-vector store serving one lane pair: two synchronous read ports sharing
// a read enable (so a stall freezes both outputs) and one write port.
module multiplier_pipe_vector_bank
   import multiplier_pipe_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int IDX_W  = IDX_W_DEF
) (
   input  logic              clk,
   input  logic              i_rden,
   input  logic [IDX_W-1:0]  i_addr_a,
   input  logic [IDX_W-1:0]  i_addr_b,
   output logic [DATA_W-1:0] o_data_a,
   output logic [DATA_W-1:0] o_data_b,
   input  logic              i_wr_en,
   input  logic [IDX_W-1:0]  i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data
);

   logic [DATA_W-1:0] r_mem [2**IDX_W];
   logic [DATA_W-1:0] r_data_a;
   logic [DATA_W-1:0] r_data_b;

   // Vector load port; contents are never cleared by reset.
   always_ff @(posedge clk) begin
      if (i_wr_en)
         r_mem[i_wr_addr] <= i_wr_data;
   end

   // Read ports hold their last data whenever the pipeline is stalled.
   always_ff @(posedge clk) begin
      if (i_rden) begin
         r_data_a <= r_mem[i_addr_a];
         r_data_b <= r_mem[i_addr_b];
      end
   end

   assign o_data_a = r_data_a;
   assign o_data_b = r_data_b;

endmodule

// File: rtl/multiplier_pipe.sv
// SpMV multiply stage: two-stage pipeline computing value * x[col] per lane,
// with valid/ready backpressure, lane masking, row-end tagging and a runtime
// loadable vector store.
module multiplier_pipe
   import multiplier_pipe_pkg::*;
#(
   parameter int NUM_CHANNELS = 4,
   parameter int DATA_W       = DATA_W_DEF,
   parameter int IDX_W        = IDX_W_DEF,
   parameter int SAT_MODE     = 0
) (
   input  logic              clk,
   input  logic              rst_l,
   multiplier_pipe_if.slave  bus,
   input  logic              vec_wr_en,
   input  logic [IDX_W-1:0]  vec_wr_addr,
   input  logic [DATA_W-1:0] vec_wr_data,
   output logic              vec_wr_err,
   output logic              busy,
   output logic [31:0]       beat_count
);

   localparam int        NUM_BANKS = NUM_CHANNELS / 2;
   localparam sat_mode_e MODE      = (SAT_MODE != 0) ? SAT_CLAMP : SAT_WRAP;

   logic                           w_en;
   logic                           w_busy;
   logic                           w_wr_ok;
   logic [NUM_CHANNELS*DATA_W-1:0] w_rd_data;
   logic [NUM_CHANNELS*DATA_W-1:0] w_products;

   logic                           r_s1_valid;
   logic [NUM_CHANNELS*DATA_W-1:0] r_s1_values;
   logic [NUM_CHANNELS-1:0]        r_s1_mask;
   logic                           r_s1_last;

   logic                           r_out_valid;
   logic [NUM_CHANNELS*DATA_W-1:0] r_out_products;
   logic [NUM_CHANNELS-1:0]        r_out_mask;
   logic                           r_out_last;

   logic                           r_wr_err;
   logic [31:0]                    r_beat_count;

   // Full signed product of two DATA_W operands, via sign extension so the
   // low 2*DATA_W bits of the unsigned multiply are the signed result.
   function automatic logic [2*DATA_W-1:0] full_product(input logic signed [DATA_W-1:0] a,
                                                        input logic signed [DATA_W-1:0] b);
      logic [2*DATA_W-1:0] a_ext;
      logic [2*DATA_W-1:0] b_ext;
      a_ext = {{DATA_W{a[DATA_W-1]}}, a};
      b_ext = {{DATA_W{b[DATA_W-1]}}, b};
      full_product = a_ext * b_ext;
   endfunction

   // Narrow a full product to DATA_W: wrap keeps the low bits, clamp pins to
   // the signed range whenever the upper bits are not a pure sign extension.
   function automatic logic signed [DATA_W-1:0] fit_product(input logic [2*DATA_W-1:0] full);
      logic ovf;
      ovf = (full[2*DATA_W-1:DATA_W-1] != {(DATA_W+1){full[2*DATA_W-1]}});
      if (MODE == SAT_CLAMP && ovf)
         fit_product = full[2*DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                        : {1'b0, {(DATA_W-1){1'b1}}};
      else
         fit_product = full[DATA_W-1:0];
   endfunction

   // Whole pipeline advances together; only a held output beat stalls it.
   assign w_en    = !r_out_valid || bus.out_ready;
   assign w_busy  = r_s1_valid || r_out_valid;
   // Writes only when nothing is in flight or arriving, so no read can race them.
   assign w_wr_ok = vec_wr_en && !w_busy && !bus.in_valid;

   for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
      multiplier_pipe_vector_bank #(
         .DATA_W (DATA_W),
         .IDX_W  (IDX_W)
      ) u_bank (
         .clk       (clk),
         .i_rden    (w_en),
         .i_addr_a  (bus.in_cols[(2*k)*IDX_W +: IDX_W]),
         .i_addr_b  (bus.in_cols[(2*k+1)*IDX_W +: IDX_W]),
         .o_data_a  (w_rd_data[(2*k)*DATA_W +: DATA_W]),
         .o_data_b  (w_rd_data[(2*k+1)*DATA_W +: DATA_W]),
         .i_wr_en   (w_wr_ok),
         .i_wr_addr (vec_wr_addr),
         .i_wr_data (vec_wr_data)
      );
   end

   // Per-lane products for the beat sitting in S1; padding lanes forced to 0.
   always_comb begin
      w_products = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         if (r_s1_mask[i])
            w_products[i*DATA_W +: DATA_W] =
               fit_product(full_product(r_s1_values[i*DATA_W +: DATA_W],
                                        w_rd_data[i*DATA_W +: DATA_W]));
      end
   end

   // S1: capture the incoming beat alongside the bank read it issued.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_s1_valid  <= 1'b0;
         r_s1_values <= '0;
         r_s1_mask   <= '0;
         r_s1_last   <= 1'b0;
      end else if (w_en) begin
         r_s1_valid  <= bus.in_valid;
         r_s1_values <= bus.in_values;
         r_s1_mask   <= bus.in_mask;
         r_s1_last   <= bus.in_last;
      end
   end

   // S2: register products and sideband into the output beat.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_out_valid    <= 1'b0;
         r_out_products <= '0;
         r_out_mask     <= '0;
         r_out_last     <= 1'b0;
      end else if (w_en) begin
         r_out_valid    <= r_s1_valid;
         r_out_products <= w_products;
         r_out_mask     <= r_s1_mask;
         r_out_last     <= r_s1_last;
      end
   end

   // Rejected-write pulse and accepted output beat counter.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_wr_err     <= 1'b0;
         r_beat_count <= '0;
      end else begin
         r_wr_err <= vec_wr_en && !w_wr_ok;
         if (r_out_valid && bus.out_ready)
            r_beat_count <= r_beat_count + 32'd1;
      end
   end

   assign bus.in_ready     = w_en;
   assign bus.out_valid    = r_out_valid;
   assign bus.out_products = r_out_products;
   assign bus.out_mask     = r_out_mask;
   assign bus.out_last     = r_out_last;
   assign vec_wr_err       = r_wr_err;
   assign busy             = w_busy;
   assign beat_count       = r_beat_count;

endmodule

// File: tb/tb_multiplier_pipe.sv
// Directed bench for multiplier_pipe: table of single beats plus hand-written
// streaming, stall, vector-write and reset sequences. A second instance is
// built with clamping products.
module tb_multiplier_pipe;

   logic clk;
   logic rst_l;

   multiplier_pipe_if #(.NUM_CHANNELS(4), .DATA_W(32), .IDX_W(10)) bus1 ();
   multiplier_pipe_if #(.NUM_CHANNELS(4), .DATA_W(32), .IDX_W(10)) bus2 ();

   logic        vec_wr_en1, vec_wr_en2;
   logic [9:0]  vec_wr_addr1, vec_wr_addr2;
   logic [31:0] vec_wr_data1, vec_wr_data2;
   logic        vec_wr_err1, vec_wr_err2;
   logic        busy1, busy2;
   logic [31:0] beat_count1, beat_count2;

   multiplier_pipe #(.NUM_CHANNELS(4), .DATA_W(32), .IDX_W(10), .SAT_MODE(0)) u_dut_wrap (
      .clk         (clk),
      .rst_l       (rst_l),
      .bus         (bus1),
      .vec_wr_en   (vec_wr_en1),
      .vec_wr_addr (vec_wr_addr1),
      .vec_wr_data (vec_wr_data1),
      .vec_wr_err  (vec_wr_err1),
      .busy        (busy1),
      .beat_count  (beat_count1)
   );

   multiplier_pipe #(.NUM_CHANNELS(4), .DATA_W(32), .IDX_W(10), .SAT_MODE(1)) u_dut_sat (
      .clk         (clk),
      .rst_l       (rst_l),
      .bus         (bus2),
      .vec_wr_en   (vec_wr_en2),
      .vec_wr_addr (vec_wr_addr2),
      .vec_wr_data (vec_wr_data2),
      .vec_wr_err  (vec_wr_err2),
      .busy        (busy2),
      .beat_count  (beat_count2)
   );

   typedef struct {
      logic [127:0] values;
      logic [39:0]  cols;
      logic [3:0]   mask;
      logic         last;
      logic [127:0] exp;
   } vec_t;

   vec_t         tbl[6];
   int           n_cmp = 0;
   int           n_fail = 0;
   int           cyc = 0;
   int           last_cyc = 0;
   int           n_rx = 0;
   int           exp_beats = 0;
   bit           mon_en = 0;
   bit           gap_chk = 0;
   logic [127:0] exp_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Stream scoreboard: every accepted output beat must match the next expected one.
   always @(negedge clk) begin
      if (mon_en && bus1.out_valid && bus1.out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_beat", 128'd1, 128'd0);
         end else begin
            chk("stream_prod", bus1.out_products, exp_q.pop_front());
            if (gap_chk && n_rx > 0)
               chk("stream_gap", 128'(cyc - last_cyc), 128'd1);
            last_cyc = cyc;
            n_rx++;
         end
      end
   end

   // Called at posedge+1; leaves at the negedge where the product is visible.
   task automatic run_single(input vec_t t, input string nm);
      @(posedge clk); #1;
      bus1.in_values = t.values;
      bus1.in_cols   = t.cols;
      bus1.in_mask   = t.mask;
      bus1.in_last   = t.last;
      bus1.in_valid  = 1'b1;
      @(posedge clk); #1;
      bus1.in_valid  = 1'b0;
      @(negedge clk);
      chk({nm, "_early_valid"}, 128'(bus1.out_valid), 128'd0);
      @(negedge clk);
      chk({nm, "_valid"}, 128'(bus1.out_valid), 128'd1);
      chk({nm, "_prod"}, bus1.out_products, t.exp);
      chk({nm, "_mask"}, 128'(bus1.out_mask), 128'(t.mask));
      chk({nm, "_last"}, 128'(bus1.out_last), 128'(t.last));
      exp_beats++;
   endtask

   // Called at posedge+1; pushes 8 beats honouring in_ready.
   task automatic stream8(input int base, input bit chk_rdy);
      logic [127:0] v;
      logic [127:0] e;
      int           guard;
      bit           acc;
      for (int k = 0; k < 8; k++) begin
         for (int j = 0; j < 4; j++) begin
            v[j*32 +: 32] = 4*k + j + 1 + base;
            e[j*32 +: 32] = (4*k + j + 1 + base) * (j + 1);
         end
         exp_q.push_back(e);
         bus1.in_values = v;
         bus1.in_cols   = {10'd3, 10'd2, 10'd1, 10'd0};
         bus1.in_mask   = 4'hF;
         bus1.in_last   = (k == 7);
         bus1.in_valid  = 1'b1;
         guard = 0;
         acc = 1'b0;
         while (!acc && guard < 40) begin
            @(negedge clk);
            acc = bus1.in_ready;
            if (chk_rdy)
               chk("stream_in_ready", 128'(acc), 128'd1);
            @(posedge clk); #1;
            guard++;
         end
         if (!acc)
            chk("accept_timeout", 128'd0, 128'd1);
      end
      bus1.in_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] snap;
      int           guard;

      tbl[0] = '{values: {32'd5, 32'd4, 32'd3, 32'd2},
                 cols: {10'd1023, 10'd2, 10'd1, 10'd0}, mask: 4'hF, last: 1'b0,
                 exp: {32'd5120, 32'd12, 32'd6, 32'd2}};
      tbl[1] = '{values: {32'd100, 32'd0, 32'd7, 32'hFFFFFFFD},
                 cols: {10'd12, 10'd11, 10'd10, 10'd9}, mask: 4'hF, last: 1'b1,
                 exp: {32'd1300, 32'd0, 32'd77, 32'hFFFFFFE2}};
      tbl[2] = '{values: {32'd8, 32'd7, 32'd6, 32'd5},
                 cols: {10'd6, 10'd5, 10'd4, 10'd3}, mask: 4'b0101, last: 1'b1,
                 exp: {32'd0, 32'd42, 32'd0, 32'd20}};
      tbl[3] = '{values: {32'd0, 32'd0, 32'd0, 32'h7FFFFFFF},
                 cols: {10'd0, 10'd0, 10'd0, 10'd1}, mask: 4'b0001, last: 1'b0,
                 exp: {32'd0, 32'd0, 32'd0, 32'hFFFFFFFE}};
      tbl[4] = '{values: {32'hFFFFFFFE, 32'h40000000, 32'h80000000, 32'd1},
                 cols: {10'd1023, 10'd3, 10'd1, 10'd0}, mask: 4'hF, last: 1'b1,
                 exp: {32'hFFFFF800, 32'd0, 32'd0, 32'd1}};
      tbl[5] = '{values: {32'd1000, 32'd1, 32'hFFFFFFFF, 32'd9},
                 cols: {10'd500, 10'd511, 10'd512, 10'd1022}, mask: 4'b1110, last: 1'b0,
                 exp: {32'd501000, 32'd512, 32'hFFFFFDFF, 32'd0}};

      bus1.in_valid = 1'b0; bus1.in_values = '0; bus1.in_cols = '0;
      bus1.in_mask = '0; bus1.in_last = 1'b0; bus1.out_ready = 1'b1;
      bus2.in_valid = 1'b0; bus2.in_values = '0; bus2.in_cols = '0;
      bus2.in_mask = '0; bus2.in_last = 1'b0; bus2.out_ready = 1'b1;
      vec_wr_en1 = 1'b0; vec_wr_addr1 = '0; vec_wr_data1 = '0;
      vec_wr_en2 = 1'b0; vec_wr_addr2 = '0; vec_wr_data2 = '0;

      // Reset state
      rst_l = 1'b1;
      #2 rst_l = 1'b0;
      #1;
      chk("rst_out_valid", 128'(bus1.out_valid), 128'd0);
      chk("rst_out_products", bus1.out_products, 128'd0);
      chk("rst_out_mask", 128'(bus1.out_mask), 128'd0);
      chk("rst_out_last", 128'(bus1.out_last), 128'd0);
      chk("rst_busy", 128'(busy1), 128'd0);
      chk("rst_beat_count", 128'(beat_count1), 128'd0);
      chk("rst_wr_err", 128'(vec_wr_err1), 128'd0);
      repeat (3) @(negedge clk);
      rst_l = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 128'(bus1.in_ready), 128'd1);

      // Vector load x[i] = i+1; clamp instance gets x[0] = 2
      for (int i = 0; i < 1024; i++) begin
         @(posedge clk); #1;
         vec_wr_en1 = 1'b1; vec_wr_addr1 = 10'(i); vec_wr_data1 = 32'(i + 1);
         vec_wr_en2 = (i == 0); vec_wr_addr2 = '0; vec_wr_data2 = 32'd2;
      end
      @(posedge clk); #1;
      vec_wr_en1 = 1'b0;
      vec_wr_en2 = 1'b0;
      @(negedge clk);
      chk("load_no_err", 128'(vec_wr_err1), 128'd0);

      // Table of single beats
      for (int i = 0; i < 6; i++)
         run_single(tbl[i], $sformatf("tbl%0d", i));
      @(posedge clk); #1;
      chk("beat_count_tbl", 128'(beat_count1), 128'(exp_beats));

      // Clamp instance: positive and negative saturation, in-range lane, masked lane
      bus2.in_values = {32'd0, 32'd5, 32'h80000000, 32'h7FFFFFFF};
      bus2.in_cols   = '0;
      bus2.in_mask   = 4'b0111;
      bus2.in_last   = 1'b1;
      bus2.in_valid  = 1'b1;
      @(posedge clk); #1;
      bus2.in_valid  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("sat_valid", 128'(bus2.out_valid), 128'd1);
      chk("sat_prod", bus2.out_products, {32'd0, 32'd10, 32'h80000000, 32'h7FFFFFFF});
      chk("sat_last", 128'(bus2.out_last), 128'd1);

      // Write while a beat is in flight is dropped
      @(posedge clk); #1;
      bus1.in_values = {32'd1, 32'd1, 32'd1, 32'd1};
      bus1.in_cols   = {10'd5, 10'd5, 10'd5, 10'd5};
      bus1.in_mask   = 4'hF;
      bus1.in_last   = 1'b0;
      bus1.in_valid  = 1'b1;
      @(posedge clk); #1;
      bus1.in_valid  = 1'b0;
      vec_wr_en1 = 1'b1; vec_wr_addr1 = 10'd5; vec_wr_data1 = 32'd999;
      @(negedge clk);
      chk("busy_in_flight", 128'(busy1), 128'd1);
      @(posedge clk); #1;
      vec_wr_en1 = 1'b0;
      @(negedge clk);
      chk("wr_err_busy", 128'(vec_wr_err1), 128'd1);
      chk("wr_busy_beat_valid", 128'(bus1.out_valid), 128'd1);
      chk("wr_busy_beat_prod", bus1.out_products, {32'd6, 32'd6, 32'd6, 32'd6});
      @(posedge clk);
      @(negedge clk);
      chk("wr_err_pulse_end", 128'(vec_wr_err1), 128'd0);
      // Write coinciding with in_valid is dropped too; store must still hold 6
      @(posedge clk); #1;
      bus1.in_values = {32'd2, 32'd2, 32'd2, 32'd2};
      bus1.in_valid  = 1'b1;
      vec_wr_en1 = 1'b1; vec_wr_addr1 = 10'd5; vec_wr_data1 = 32'd777;
      @(negedge clk);
      chk("idle_before_wr", 128'(busy1), 128'd0);
      @(posedge clk); #1;
      bus1.in_valid = 1'b0;
      vec_wr_en1 = 1'b0;
      @(negedge clk);
      chk("wr_err_in_valid", 128'(vec_wr_err1), 128'd1);
      @(negedge clk);
      chk("store_unchanged_valid", 128'(bus1.out_valid), 128'd1);
      chk("store_unchanged_prod", bus1.out_products, {32'd12, 32'd12, 32'd12, 32'd12});
      exp_beats += 2;

      // Eight back-to-back beats, out_ready held high
      @(posedge clk); #1;
      mon_en = 1'b1;
      gap_chk = 1'b1;
      stream8(0, 1'b1);
      guard = 0;
      while (exp_q.size() != 0 && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      chk("stream1_drain", 128'(exp_q.size()), 128'd0);
      gap_chk = 1'b0;

      // Eight beats with out_ready dropped for five cycles mid-stream
      @(posedge clk); #1;
      fork
         stream8(100, 1'b0);
         begin
            repeat (3) @(posedge clk);
            #1 bus1.out_ready = 1'b0;
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               if (i == 0)
                  snap = bus1.out_products;
               else
                  chk("stall_hold_prod", bus1.out_products, snap);
               chk("stall_in_ready", 128'(bus1.in_ready), 128'd0);
               chk("stall_out_valid", 128'(bus1.out_valid), 128'd1);
               if (i < 4)
                  @(posedge clk);
            end
            @(posedge clk); #1;
            bus1.out_ready = 1'b1;
         end
      join
      guard = 0;
      while (exp_q.size() != 0 && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      chk("stream2_drain", 128'(exp_q.size()), 128'd0);
      chk("stream_rx_count", 128'(n_rx), 128'd16);
      mon_en = 1'b0;
      exp_beats += 16;
      repeat (2) @(posedge clk);
      #1;
      chk("beat_count_total", 128'(beat_count1), 128'(exp_beats));

      // Asynchronous reset in the middle of a stream
      bus1.in_values = tbl[1].values;
      bus1.in_cols   = tbl[1].cols;
      bus1.in_mask   = tbl[1].mask;
      bus1.in_last   = tbl[1].last;
      bus1.in_valid  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("pre_rst_busy", 128'(busy1), 128'd1);
      #1 rst_l = 1'b0;
      #1;
      chk("mid_rst_out_valid", 128'(bus1.out_valid), 128'd0);
      chk("mid_rst_busy", 128'(busy1), 128'd0);
      chk("mid_rst_beat_count", 128'(beat_count1), 128'd0);
      chk("mid_rst_in_ready", 128'(bus1.in_ready), 128'd1);
      bus1.in_valid = 1'b0;
      @(negedge clk);
      rst_l = 1'b1;
      run_single(tbl[0], "post_rst");
      @(posedge clk); #1;
      chk("post_rst_beat_count", 128'(beat_count1), 128'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
